// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - ALU, load/store and register-file write port signals for the writeback block
interface regfile_writeback_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;

    logic        ls_valid;
    logic        ls_ready;
    logic [4:0]  ls_rd;
    logic [31:0] ls_data;

    logic        rf_write_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;

    modport master (
        output alu_valid, alu_rd, alu_data, ls_valid, ls_rd, ls_data,
        input  alu_stall, ls_ready, rf_write_en, rf_rd_addr, rf_rd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ls_valid, ls_rd, ls_data,
        output alu_stall, ls_ready, rf_write_en, rf_rd_addr, rf_rd_data
    );
endinterface

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file writeback arbiter, load/store result FIFO and pending-write scoreboard
// Optional operand bypass from the write port is enabled by defining WB_BYPASS_EN.
module regfile_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    regfile_writeback_if.slave wb,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rs1_fwd_valid,
    output logic        rs2_fwd_valid,
    output logic [31:0] rs1_fwd_data,
    output logic [31:0] rs2_fwd_data
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [4:0]    fifo_rd   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_full;
    logic          fifo_empty;
    logic          alu_sel;
    logic          pop;
    logic          push;

    logic [31:0]   pending;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;

    always_comb begin
        fifo_full   = (count == DEPTH_C);
        fifo_empty  = (count == '0);
        wb.ls_ready = !fifo_full;
        wb.alu_stall = fifo_full;
        // A zero-destination ALU result is dropped and leaves the slot free for the FIFO.
        alu_sel     = wb.alu_valid && (wb.alu_rd != 5'd0);
        pop         = !alu_sel && !fifo_empty;
        push        = wb.ls_valid && !fifo_full && (wb.ls_rd != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb.ls_rd;
            fifo_data[wr_ptr] <= wb.ls_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb.rf_write_en <= 1'b0;
            wb.rf_rd_addr  <= 5'd0;
            wb.rf_rd_data  <= 32'd0;
        end else if (alu_sel) begin
            wb.rf_write_en <= 1'b1;
            wb.rf_rd_addr  <= wb.alu_rd;
            wb.rf_rd_data  <= wb.alu_data;
        end else if (pop) begin
            wb.rf_write_en <= 1'b1;
            wb.rf_rd_addr  <= fifo_rd[rd_ptr];
            wb.rf_rd_data  <= fifo_data[rd_ptr];
        end else begin
            wb.rf_write_en <= 1'b0;
            wb.rf_rd_addr  <= 5'd0;
            wb.rf_rd_data  <= 32'd0;
        end
    end

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_valid) set_mask = 32'd1 << issue_rd;
        if (wb.rf_write_en) clr_mask = 32'd1 << wb.rf_rd_addr;
    end

    // Clear is applied before set so a same-edge reissue keeps the bit; bit 0 never holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= 32'd0;
        else          pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rs1_fwd_valid = wb.rf_write_en && (wb.rf_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
        rs2_fwd_valid = wb.rf_write_en && (wb.rf_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
        rs1_fwd_data  = wb.rf_rd_data;
        rs2_fwd_data  = wb.rf_rd_data;
        rs1_busy      = pending[rs1_addr] && !rs1_fwd_valid;
        rs2_busy      = pending[rs2_addr] && !rs2_fwd_valid;
    end
`else
    always_comb begin
        rs1_fwd_valid = 1'b0;
        rs2_fwd_valid = 1'b0;
        rs1_fwd_data  = 32'd0;
        rs2_fwd_data  = 32'd0;
        rs1_busy      = pending[rs1_addr];
        rs2_busy      = pending[rs2_addr];
    end
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback against a queue-based reference model
module tb_regfile_writeback;
    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rs1_fwd_valid;
    logic        rs2_fwd_valid;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;

    regfile_writeback_if wb ();

    regfile_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb            (wb.slave),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic [4:0]  outs[$];
    bit [31:0]   pend;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          last_accept;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        outs.delete();
        pend   = '0;
        m_we   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_rd     = 5'd0;
        wb.alu_valid = 1'b0;
        wb.alu_rd    = 5'd0;
        wb.alu_data  = 32'd0;
        wb.ls_valid  = 1'b0;
        wb.ls_rd     = 5'd0;
        wb.ls_data   = 32'd0;
    endtask

    task automatic chk_src(input string n, input logic [4:0] a, input logic busy,
                           input logic fv, input logic [31:0] fd);
        bit ef;
`ifdef WB_BYPASS_EN
        ef = m_we && (m_addr == a) && (a != 5'd0);
`else
        ef = 1'b0;
        check_eq({n, "_fwd_data_tied"}, fd, 32'd0);
`endif
        check_eq({n, "_fwd_valid"}, fv, ef);
        if (ef) check_eq({n, "_fwd_data"}, fd, m_data);
        check_eq({n, "_busy"}, busy, pend[a] && !ef);
    endtask

    // One clock: check combinational outputs, advance the model at the edge, check the registered port.
    task automatic step();
        bit        asel;
        bit        accept;
        bit [31:0] clr;
        bit [31:0] set;
        ent_t      e;
        #1;
        check_eq("ls_ready", wb.ls_ready, q.size() < DEPTH);
        check_eq("alu_stall", wb.alu_stall, q.size() == DEPTH);
        chk_src("rs1", rs1_addr, rs1_busy, rs1_fwd_valid, rs1_fwd_data);
        chk_src("rs2", rs2_addr, rs2_busy, rs2_fwd_valid, rs2_fwd_data);
        asel   = wb.alu_valid && (wb.alu_rd != 5'd0);
        accept = wb.ls_valid && (q.size() < DEPTH);
        clr    = m_we ? (32'd1 << m_addr) : 32'd0;
        set    = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
        e.rd   = wb.ls_rd;
        e.data = wb.ls_data;
        @(posedge clk);
        pend    = (pend & ~clr) | set;
        pend[0] = 1'b0;
        if (asel) begin
            m_we   = 1'b1;
            m_addr = wb.alu_rd;
            m_data = wb.alu_data;
        end else if (q.size() > 0) begin
            ent_t h;
            h      = q.pop_front();
            m_we   = 1'b1;
            m_addr = h.rd;
            m_data = h.data;
        end else begin
            m_we = 1'b0;
        end
        if (accept && e.rd != 5'd0) q.push_back(e);
        last_accept = accept;
        @(negedge clk);
        check_eq("rf_write_en", wb.rf_write_en, m_we);
        if (m_we) begin
            check_eq("rf_rd_addr", wb.rf_rd_addr, m_addr);
            check_eq("rf_rd_data", wb.rf_rd_data, m_data);
        end
    endtask

    initial begin
        idle_inputs();
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        reset_n  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_rf_write_en", wb.rf_write_en, 1'b0);
        check_eq("reset_rf_rd_addr", wb.rf_rd_addr, 5'd0);
        check_eq("reset_rf_rd_data", wb.rf_rd_data, 32'd0);
        check_eq("reset_ls_ready", wb.ls_ready, 1'b1);
        check_eq("reset_alu_stall", wb.alu_stall, 1'b0);
        check_eq("reset_rs1_busy", rs1_busy, 1'b0);
        check_eq("reset_rs1_fwd_valid", rs1_fwd_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU single result
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
        step();
        check_eq("alu_we", wb.rf_write_en, 1'b1);
        check_eq("alu_addr", wb.rf_rd_addr, 5'd5);
        check_eq("alu_data", wb.rf_rd_data, 32'hDEADBEEF);
        idle_inputs();
        step();
        check_eq("alu_we_pulse", wb.rf_write_en, 1'b0);

        // Long-latency result with scoreboard
        rs1_addr = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle_inputs();
        check_eq("ls_busy_set", rs1_busy, 1'b1);
        wb.ls_valid = 1'b1; wb.ls_rd = 5'd7; wb.ls_data = 32'h12345678;
        step();
        idle_inputs();
        check_eq("ls_no_early_write", wb.rf_write_en, 1'b0);
        step();
        check_eq("ls_we", wb.rf_write_en, 1'b1);
        check_eq("ls_addr", wb.rf_rd_addr, 5'd7);
        check_eq("ls_data", wb.rf_rd_data, 32'h12345678);
`ifdef WB_BYPASS_EN
        check_eq("ls_busy_bypass", rs1_busy, 1'b0);
        check_eq("ls_fwd_valid", rs1_fwd_valid, 1'b1);
        check_eq("ls_fwd_data", rs1_fwd_data, 32'h12345678);
`else
        check_eq("ls_busy_hold", rs1_busy, 1'b1);
`endif
        step();
        check_eq("ls_busy_clear", rs1_busy, 1'b0);

        // FIFO fill under continuous ALU traffic, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(10 + i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'(i);
            wb.ls_valid  = 1'b1; wb.ls_rd = 5'(10 + i); wb.ls_data = 32'hA0 + 32'(i);
            step();
        end
        wb.ls_valid = 1'b0;
        #1;
        check_eq("full_ls_ready", wb.ls_ready, 1'b0);
        check_eq("full_alu_stall", wb.alu_stall, 1'b1);
        step();
        check_eq("stall_alu_wins", wb.rf_rd_addr, 5'd3);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            check_eq("drain_addr", wb.rf_rd_addr, 5'(10 + i));
            check_eq("drain_data", wb.rf_rd_data, 32'hA0 + 32'(i));
        end
        step();
        check_eq("drain_done", wb.rf_write_en, 1'b0);

        // Zero destinations
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h5555;
        wb.ls_valid  = 1'b1; wb.ls_rd = 5'd0; wb.ls_data = 32'h6666;
        #1;
        check_eq("rd0_handshake", wb.ls_ready, 1'b1);
        step();
        idle_inputs();
        check_eq("rd0_no_write", wb.rf_write_en, 1'b0);
        step();
        check_eq("rd0_no_push", wb.rf_write_en, 1'b0);

        // Same-edge set and clear of one register
        rs1_addr = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle_inputs();
        wb.ls_valid = 1'b1; wb.ls_rd = 5'd9; wb.ls_data = 32'h99;
        step();
        idle_inputs();
        step();
        check_eq("reissue_commit_addr", wb.rf_rd_addr, 5'd9);
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        idle_inputs();
        check_eq("reissue_busy", rs1_busy, 1'b1);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 2; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(12 + i);
            step();
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h300 + 32'(i);
            wb.ls_valid  = 1'b1; wb.ls_rd = 5'(12 + i); wb.ls_data = 32'hC0 + 32'(i);
            step();
        end
        wb.ls_valid = 1'b0;
        step();
        rs1_addr = 5'd12;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_we", wb.rf_write_en, 1'b0);
        check_eq("arst_addr", wb.rf_rd_addr, 5'd0);
        check_eq("arst_data", wb.rf_rd_data, 32'd0);
        check_eq("arst_busy", rs1_busy, 1'b0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_eq("post_rst_ls_ready", wb.ls_ready, 1'b1);
        check_eq("post_rst_alu_stall", wb.alu_stall, 1'b0);
        check_eq("post_rst_we", wb.rf_write_en, 1'b0);

        // Randomised traffic respecting the upstream hazard rules
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [4:0] r;
            int idx;
            idle_inputs();
            wb.alu_data = $urandom;
            wb.ls_data  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                r = 5'($urandom_range(1, 31));
                if (!pend[r]) begin
                    issue_valid = 1'b1;
                    issue_rd    = r;
                end
            end
            idx = -1;
            if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, outs.size() - 1);
                wb.ls_valid = 1'b1;
                wb.ls_rd    = outs[idx];
            end else if ($urandom_range(0, 9) == 0) begin
                wb.ls_valid = 1'b1;
            end
            if ($urandom_range(0, 1) == 1 && (q.size() < DEPTH || $urandom_range(0, 3) == 0)) begin
                r = 5'($urandom_range(0, 31));
                if (r == 5'd0 || (!pend[r] && !(issue_valid && r == issue_rd))) begin
                    wb.alu_valid = 1'b1;
                    wb.alu_rd    = r;
                end
            end
            rs1_addr = ($urandom_range(0, 2) == 0) ? m_addr : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            step();
            if (idx >= 0 && last_accept) outs.delete(idx);
            if (issue_valid) outs.push_back(issue_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback arbiter and scoreboard that drives the single write port of the core's 32×32 register file. It merges single-cycle ALU results with long-latency load/store results arriving over a valid/ready handshake, buffering the latter in a small FIFO. It tracks pending long-latency destinations so the issue stage can stall on read-after-write hazards. It sits between the execute/memory units and the register file write port.

## Interface
- FIFO_DEPTH, 2, load/store result buffer entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid this cycle; no backpressure
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_stall  out  1  FIFO full; upstream must hold alu_valid low
- ls_valid  in  1  load/store result valid
- ls_ready  out  1  FIFO can accept
- ls_rd  in  5  load/store destination register
- ls_data  in  32  load/store result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination register
- rs1_addr, rs2_addr  in  5 each  issue-stage source registers
- rs1_busy, rs2_busy  out  1 each  source has an uncommitted long-latency write
- rf_write_en  out  1  register file write enable (registered)
- rf_rd_addr  out  5  register file write address (registered)
- rf_rd_data  out  32  register file write data (registered)
- rs1_fwd_valid, rs2_fwd_valid  out  1 each  bypass hit (WB_BYPASS_EN only)
- rs1_fwd_data, rs2_fwd_data  out  32 each  bypass data (WB_BYPASS_EN only)

## Operation
- Reset: rf_write_en=0, rf_rd_addr=0, rf_rd_data=0, FIFO empty, all pending bits 0, ls_ready=1, alu_stall=0, busy=0, fwd outputs 0.
- Per-cycle select, highest priority first: ALU (alu_valid && alu_rd≠0); otherwise pop the FIFO head if non-empty; otherwise idle. The selection is registered into rf_* at the next edge; rf_write_en is 0 when idle.
- ALU result with alu_rd=0: discarded and does not consume the slot, so the FIFO may pop in that cycle.
- ls_ready = (count < FIFO_DEPTH), with no pass-through on a same-cycle pop. A handshake with ls_rd≠0 pushes the entry; ls_rd=0 completes the handshake but pushes nothing.
- Simultaneous push and pop: count is unchanged and order is preserved. Pointers wrap modulo FIFO_DEPTH.
- alu_stall = (count == FIFO_DEPTH). If alu_valid is asserted anyway, ALU still wins and the FIFO holds.
- Scoreboard: 32 pending bits; bit 0 is hardwired to 0.
  - issue_valid && issue_rd≠0 sets pending[issue_rd].
  - A pending bit clears at the edge where rf_write_en=1 and rf_rd_addr equals that register, which is the same edge the register file captures the data.
  - Set and clear of the same register in one edge: set wins.
- Upstream must not issue a long-latency op or ALU write to a register that is busy. Only one write may be outstanding per register.
- rsN_busy = pending[rsN_addr], combinational.

## Timing
- ALU latency: result sampled at edge E appears on rf_* during the cycle after E and is written into the register file at E+1.
- Load/store latency: a push at edge E can be popped no earlier than E+1, appears on rf_* after E+1, and commits at E+2.
- rf_write_en pulses for exactly one cycle per committed result.
- reset_n assertion clears all state immediately, including mid-drain. Release is synchronous to the next edge.

## Configuration
- WB_BYPASS_EN defined: rsN_fwd_valid = rf_write_en && rf_rd_addr == rsN_addr && rsN_addr≠0, and rsN_fwd_data = rf_rd_data. rsN_busy is forced to 0 in any cycle where rsN_fwd_valid=1, so the consumer issues one cycle earlier.
- WB_BYPASS_EN undefined: the fwd outputs are tied to 0 and busy holds until the commit edge.

## Test plan
- ALU valid, rd=5, data 0xDEADBEEF for one cycle -> next cycle rf_write_en=1, addr 5, data 0xDEADBEEF; the following cycle rf_write_en=0.
- issue rd=7, rs1_addr=7 -> rs1_busy=1; then ls handshake rd=7, data 0x12345678 with ALU idle -> rf write visible 2 cycles later. rs1_busy clears after the commit edge; with WB_BYPASS_EN it clears during the write cycle, with rs1_fwd_data=0x12345678.
- ALU valid every cycle (rd=3) while ls pushes FIFO_DEPTH results -> ls_ready=0 and alu_stall=1; then drop alu_valid -> results drain one per cycle in push order.
- ALU rd=0 and ls rd=0 -> no rf_write_en, ls handshake completes, FIFO count unchanged.
- Same-edge issue rd=9 and commit rd=9 -> rs1_busy (rs1_addr=9) stays 1.
- reset_n low with 2 FIFO entries and pending bits set -> rf_* go to 0 at once; after release FIFO is empty, busy=0, ls_ready=1, alu_stall=0.
